// File: rtl/raster_pkg.sv
// Shared raster/scanner definitions: grid geometry, capture FSM encodings, row decode helper.
package raster_pkg;

    localparam int GRID_DIM    = 8;
    localparam int PIXEL_COUNT = GRID_DIM * GRID_DIM;
    localparam int IDX_W       = $clog2(PIXEL_COUNT);
    localparam int ROW_W       = $clog2(GRID_DIM);

    typedef enum logic {
        CAP_IDLE = 1'b0,
        CAP_RUN  = 1'b1
    } cap_state_t;

    function automatic logic [GRID_DIM-1:0] row_onehot(input logic [ROW_W-1:0] row);
        return GRID_DIM'(1) << row;
    endfunction

endpackage

// File: rtl/matrix_scanner_if.sv
// Rasterizer <-> matrix scanner link: serial pixel stream in, row/column drive and status out.
interface matrix_scanner_if;
    import raster_pkg::*;

    logic [3:0]          pixel_data;
    logic                frame_sync;
    logic [GRID_DIM-1:0] row_sel;
    logic [GRID_DIM-1:0] col_data;
    logic                frame_done;
    logic                frame_drop;

    modport master (
        output pixel_data, frame_sync,
        input  row_sel, col_data, frame_done, frame_drop
    );

    modport slave (
        input  pixel_data, frame_sync,
        output row_sel, col_data, frame_done, frame_drop
    );

endinterface

// File: rtl/scan_timer.sv
// Row dwell timer: counts 0..DWELL_CYCLES-1 and ticks on the terminal count.
module scan_timer #(
    parameter int DWELL_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] o_count,
    output logic        o_tick
);

    logic [15:0] r_count;

    assign o_tick  = (r_count == 16'(DWELL_CYCLES - 1));
    assign o_count = r_count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (o_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 16'd1;
        end
    end

endmodule

// File: rtl/matrix_scanner.sv
// 8x8 LED matrix scanner: captures a serial 64-pixel frame and multiplexes it row by row.
// Optional anti-ghost row blanking on dwell count 0: define MATRIX_SCANNER_BLANK_EN.
module matrix_scanner
    import raster_pkg::*;
#(
    parameter int DWELL_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    matrix_scanner_if.slave bus
);

    cap_state_t             r_state;
    cap_state_t             w_state_next;
    logic [IDX_W-1:0]       r_idx;
    logic [PIXEL_COUNT-2:0] r_shadow;
    logic [PIXEL_COUNT-1:0] r_pending;
    logic [PIXEL_COUNT-1:0] r_display;
    logic [PIXEL_COUNT-1:0] w_frame;
    logic                   r_pending_valid;
    logic                   r_frame_done;
    logic                   r_frame_drop;
    logic [ROW_W-1:0]       r_row;
    logic [15:0]            w_count;
    logic                   w_tick;
    logic                   w_wrap;
    logic                   w_sample;
    logic                   w_complete;
    logic                   w_unused;

    scan_timer #(
        .DWELL_CYCLES(DWELL_CYCLES)
    ) u_scan_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_count(w_count),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CAP_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_sample     = 1'b0;
        w_complete   = 1'b0;
        if (bus.frame_sync) begin
            w_state_next = CAP_RUN;
        end else if (r_state == CAP_RUN) begin
            w_sample = 1'b1;
            if (r_idx == IDX_W'(PIXEL_COUNT - 1)) begin
                w_complete   = 1'b1;
                w_state_next = CAP_IDLE;
            end
        end
    end

    // The final pixel goes straight from the input into the completed frame.
    assign w_frame = {bus.pixel_data[0], r_shadow};
    assign w_wrap  = w_tick && (r_row == ROW_W'(GRID_DIM - 1));

    // NOTE: the frame buffers are cleared by reset too, so a blank image shows until the first frame lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_shadow <= '0;
        end else if (bus.frame_sync) begin
            r_idx <= '0;
        end else if (w_sample) begin
            r_idx <= r_idx + IDX_W'(1);
            if (!w_complete) begin
                r_shadow[r_idx] <= bus.pixel_data[0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
        end else if (w_tick) begin
            r_row <= r_row + ROW_W'(1);
        end
    end

    // A frame finishing on the scan wrap bypasses pending and is shown at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending       <= '0;
            r_display       <= '0;
            r_pending_valid <= 1'b0;
        end else if (w_complete && w_wrap) begin
            r_display       <= w_frame;
            r_pending_valid <= 1'b0;
        end else if (w_complete) begin
            r_pending       <= w_frame;
            r_pending_valid <= 1'b1;
        end else if (w_wrap && r_pending_valid) begin
            r_display       <= r_pending;
            r_pending_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_done <= 1'b0;
            r_frame_drop <= 1'b0;
        end else begin
            r_frame_done <= w_complete;
            r_frame_drop <= w_complete && r_pending_valid && !w_wrap;
        end
    end

    assign bus.col_data   = r_display[{r_row, 3'b000} +: GRID_DIM];
    assign bus.frame_done = r_frame_done;
    assign bus.frame_drop = r_frame_drop;

`ifdef MATRIX_SCANNER_BLANK_EN
    assign bus.row_sel = (w_count == '0) ? '0 : row_onehot(r_row);
    assign w_unused    = ^bus.pixel_data[3:1];
`else
    assign bus.row_sel = row_onehot(r_row);
    assign w_unused    = ^{bus.pixel_data[3:1], w_count};
`endif

endmodule

// File: tb/tb_matrix_scanner.sv
// Directed bench for matrix_scanner: a DWELL_CYCLES=4 instance plus a slow instance for overwrite cases.
module tb_matrix_scanner;
    import raster_pkg::*;

    localparam int FAST_DWELL = 4;
    localparam int SLOW_DWELL = 64;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   edges  = 0;

    logic [63:0] x_frame = 64'hDEAD_BEEF_CAFE_F00D;
    logic [63:0] y_frame = 64'h0102_0408_1020_4080;
    logic [63:0] p_frame = 64'h0123_4567_89AB_CDEF;
    logic [63:0] q_frame = 64'hFEDC_BA98_7654_3210;
    logic [63:0] r_frame = 64'h5555_AAAA_3333_CCCC;

    matrix_scanner_if bus ();
    matrix_scanner_if bus_slow ();

    assign bus_slow.pixel_data = bus.pixel_data;
    assign bus_slow.frame_sync = bus.frame_sync;

    matrix_scanner #(.DWELL_CYCLES(FAST_DWELL)) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    matrix_scanner #(.DWELL_CYCLES(SLOW_DWELL)) u_dut_slow (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_slow)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_row(input int m, input int dwell);
`ifdef MATRIX_SCANNER_BLANK_EN
        if (m % dwell == 0) return 8'h00;
`endif
        return 8'h01 << ((m / dwell) % 8);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic run_to(input int target);
        while (edges < target) tick();
    endtask

    // Sync pulse, then 64 samples; bits 3:1 carry junk that must be ignored.
    task automatic send_frame(input logic [63:0] f, input logic drop_fast, input logic drop_slow,
                              input string tag);
        bus.frame_sync = 1'b1;
        tick();
        bus.frame_sync = 1'b0;
        check({tag, "_done_low"}, {bus.frame_done, bus_slow.frame_done}, 0);
        for (int n = 0; n < 64; n++) begin
            bus.pixel_data = {3'b101, f[n]};
            tick();
            if (n != 63)
                check({tag, "_early"}, {bus.frame_done, bus.frame_drop,
                                        bus_slow.frame_done, bus_slow.frame_drop}, 0);
        end
        check({tag, "_flags"}, {bus.frame_done, bus.frame_drop, bus_slow.frame_done, bus_slow.frame_drop},
              {1'b1, drop_fast, 1'b1, drop_slow});
        bus.pixel_data = 4'h0;
    endtask

    task automatic abort_partial(input int k);
        bus.frame_sync = 1'b1;
        tick();
        bus.frame_sync = 1'b0;
        for (int n = 0; n < k; n++) begin
            bus.pixel_data = 4'b1110;
            tick();
            check("partial_no_done", {bus.frame_done, bus_slow.frame_done}, 0);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.frame_sync = 1'b0;
        bus.pixel_data = 4'h0;
        #3;
        check("reset_row_sel", bus.row_sel, exp_row(0, FAST_DWELL));
        check("reset_col", bus.col_data, 0);
        check("reset_flags", {bus.frame_done, bus.frame_drop}, 0);
        check("reset_slow_row_sel", bus_slow.row_sel, exp_row(0, SLOW_DWELL));
        @(negedge clk);
        rst_n = 1'b1;
        edges = 0;

        // Idle scan: every row for 4 cycles, blank columns, wrap back to row 0.
        for (int i = 0; i < 33; i++) begin
            tick();
            check("idle_row_sel", bus.row_sel, exp_row(edges, FAST_DWELL));
            check("idle_col", bus.col_data, 0);
        end

        // Single pixel at n=9 (y=1, x=1); completes at edge 98, shown from the wrap at 128.
        run_to(33);
        send_frame(64'h0000_0000_0000_0200, 1'b0, 1'b0, "pix9");
        run_to(101);
        check("pix9_not_yet_shown", bus.col_data, 0);
        for (int r = 0; r < 8; r++) begin
            run_to(128 + 4 * r);
            check("pix9_row_sel", bus.row_sel, exp_row(edges, FAST_DWELL));
            check("pix9_col", bus.col_data, (r == 1) ? 8'h02 : 8'h00);
        end

        // Back-to-back frames: the slow instance still holds pending, so both overwrite with a drop.
        run_to(160);
        send_frame(x_frame, 1'b0, 1'b1, "frame_x");
        send_frame(y_frame, 1'b0, 1'b1, "frame_y");
        for (int r = 0; r < 8; r++) begin
            run_to(512 + 64 * r);
            check("slow_row_sel", bus_slow.row_sel, exp_row(edges, SLOW_DWELL));
            check("slow_newest_col", bus_slow.col_data, y_frame[8 * r +: 8]);
        end

        // Abort after 30 zero samples, then an all-ones frame; shown at wrap 1088.
        run_to(970);
        abort_partial(30);
        send_frame(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, "ones");
        for (int r = 0; r < 8; r++) begin
            run_to(1088 + 4 * r);
            check("ones_col", bus.col_data, 8'hFF);
        end

        // Completion on the fast wrap (edge 1216): displayed immediately, no drop.
        run_to(1151);
        send_frame(p_frame, 1'b0, 1'b1, "aligned_fast");
        check("aligned_fast_row0", bus.col_data, p_frame[7:0]);
        run_to(1220);
        check("aligned_fast_row1", bus.col_data, p_frame[15:8]);

        // Completion on the slow wrap (edge 1536) with pending set: direct load, no drop, pending cleared.
        run_to(1471);
        send_frame(q_frame, 1'b0, 1'b0, "aligned_slow");
        check("aligned_slow_row0", bus_slow.col_data, q_frame[7:0]);
        check("aligned_both_row0", bus.col_data, q_frame[7:0]);
        send_frame(r_frame, 1'b0, 1'b0, "after_aligned");

        // Reset while sample n=40 is on the input.
        run_to(1610);
        bus.frame_sync = 1'b1;
        tick();
        bus.frame_sync = 1'b0;
        for (int n = 0; n < 40; n++) begin
            bus.pixel_data = 4'b0001;
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midcap_rst_row_sel", bus.row_sel, exp_row(0, FAST_DWELL));
        check("midcap_rst_col", bus.col_data, 0);
        check("midcap_rst_flags", {bus.frame_done, bus.frame_drop, bus_slow.frame_done, bus_slow.frame_drop}, 0);
        check("midcap_rst_slow_row_sel", bus_slow.row_sel, exp_row(0, SLOW_DWELL));
        check("midcap_rst_slow_col", bus_slow.col_data, 0);
        @(negedge clk);
        @(negedge clk);
        check("held_rst_row_sel", bus.row_sel, exp_row(0, FAST_DWELL));
        rst_n = 1'b1;
        edges = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            check("post_rst_flags", {bus.frame_done, bus.frame_drop, bus_slow.frame_done, bus_slow.frame_drop}, 0);
            check("post_rst_row_sel", bus.row_sel, exp_row(edges, FAST_DWELL));
            check("post_rst_col", bus.col_data, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matrix_scanner.md
MATRIX_SCANNER -- requirements
Module: matrix_scanner

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 1024: clock cycles each row is driven; legal range 2..65535.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-004 SHALL have port pixel_data  input  4: serialized pixel stream from rasterizer; only bit 0 used, bits 3:1 ignored.
REQ-005 SHALL have port frame_sync  input  1: one-cycle pulse preceding a 64-pixel stream.
REQ-006 SHALL have port row_sel  output  8: row drive, active-high, at most one bit set.
REQ-007 SHALL have port col_data  output  8: column data for the driven row; bit j = pixel x=j.
REQ-008 SHALL have port frame_done  output  1: one-cycle pulse when a full 64-pixel capture completes.
REQ-009 SHALL have port frame_drop  output  1: one-cycle pulse when an undisplayed pending frame is overwritten.

Function
REQ-010 Capture FSM SHALL have states CAP_IDLE and CAP_RUN; frame_sync=1 in any state -> CAP_RUN, capture index 0.
REQ-011 In CAP_RUN, each cycle after frame_sync SHALL store pixel_data[0] into shadow bit index n (y=n[5:3], x=n[2:0]), then n increments.
REQ-012 Sample n=63 SHALL copy shadow (including bit 63) into the pending buffer, set pending_valid, pulse frame_done next cycle, return to CAP_IDLE.
REQ-013 frame_sync during CAP_RUN SHALL abort the current capture; the partial frame is never displayed; index restarts at 0.
REQ-014 Completion while pending_valid=1 SHALL overwrite pending (newest wins) and pulse frame_drop with frame_done.
REQ-015 Scan: dwell counter counts 0..DWELL_CYCLES-1; on terminal count it resets to 0 and row advances, 7 wraps to 0.
REQ-016 Display buffer SHALL update only at the row 7->0 advance; if pending_valid, display<=pending and pending_valid clears.
REQ-017 Completion and row 7->0 advance in the same cycle SHALL load the just-completed frame directly into display, leave pending_valid=0, no frame_drop.
REQ-018 row_sel SHALL equal 1<<row; col_data SHALL equal display row [row]; both are functions of registered state, no added latency.
REQ-019 Capture SHALL never stall or perturb scan timing.

Reset
REQ-020 rst_n=0 SHALL immediately clear shadow, pending, display, pending_valid, capture index, dwell, row; FSM to CAP_IDLE.
REQ-021 During and after reset: row_sel=8'h01 (8'h00 when blanking compiled in), col_data=0, frame_done=0, frame_drop=0.
REQ-022 Reset mid-capture SHALL discard the partial frame; no frame_done follows release.

Configuration
REQ-023 Macro MATRIX_SCANNER_BLANK_EN defined: row_sel SHALL be 8'h00 while dwell count is 0 (anti-ghost blank), otherwise per REQ-018.
REQ-024 Macro undefined: row_sel SHALL always be one-hot per REQ-018; col_data identical in both builds.

Structure
REQ-025 Shared package raster_pkg SHALL hold GRID_DIM=8, PIXEL_COUNT=64, capture state encodings, shared with rasterizer.
REQ-026 Dwell counter SHALL be sub-module scan_timer (parameter DWELL_CYCLES, outputs count and terminal-count tick).

Verification (DWELL_CYCLES=4)
REQ-027 Reset release, no stimulus -> row_sel sequence 01,02,...,80,01 each held 4 cycles, col_data=0 throughout.
REQ-028 frame_sync then 64 samples with only n=9 set -> frame_done 1 cycle after n=63; after next row 7->0 advance, row 1 col_data=8'h02, others 0.
REQ-029 Two back-to-back full frames inside one scan period -> second frame_done with frame_drop=1; second frame displayed.
REQ-030 frame_sync at n=30 then full all-ones frame -> single frame_done; display all rows 8'hFF.
REQ-031 Completion aligned to row 7->0 advance -> display updates that cycle, frame_drop=0, pending_valid=0.
REQ-032 rst_n low at n=40 -> outputs at reset values immediately, no frame_done; blanking build: row_sel=0 on dwell count 0.
